ql_bank_bl_wl_sequencer: RTL and testbench

- Drives the `bl`/`wl` configuration bus of one QL memory-bank region, for example a switch-block or connection-block SRAM array.
- Accepts configuration words over a valid/ready handshake. Each word is one word-line address plus one bit-line data row.
- Each word is replayed as a timed SETUP → PULSE → HOLD write cycle: bit lines are stable before, during and after a one-hot word-line pulse.
- Sits directly upstream of the routing-block `bl`/`wl` inputs and downstream of the bitstream loader.

---
 rtl/ql_bank_bl_wl_sequencer_if.sv | 37 +++
 rtl/ql_bank_bl_wl_sequencer.sv | 139 +++++++++++++
 tb/tb_ql_bank_bl_wl_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ql_bank_bl_wl_sequencer_if.sv
// Configuration word handshake plus bl/wl bank bus between the bitstream loader and the bank sequencer.
// Define QL_BANK_SEQ_PARITY_EN to add the cfg_parity input.
interface ql_bank_bl_wl_sequencer_if #(
  parameter int BL_WIDTH  = 6,
  parameter int WL_WIDTH  = 6,
  parameter int WL_ADDR_W = 3
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [WL_ADDR_W-1:0] cfg_wl_addr;
  logic [0:BL_WIDTH-1]  cfg_bl_data;
`ifdef QL_BANK_SEQ_PARITY_EN
  logic                 cfg_parity;
`endif
  logic                 clr_err;
  logic [0:BL_WIDTH-1]  bl;
  logic [0:WL_WIDTH-1]  wl;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
`ifdef QL_BANK_SEQ_PARITY_EN
    output cfg_parity,
`endif
    output cfg_valid, cfg_wl_addr, cfg_bl_data, clr_err,
    input  cfg_ready, bl, wl, busy, done, err
  );

  modport slave (
`ifdef QL_BANK_SEQ_PARITY_EN
    input  cfg_parity,
`endif
    input  cfg_valid, cfg_wl_addr, cfg_bl_data, clr_err,
    output cfg_ready, bl, wl, busy, done, err
  );
endinterface

// File: rtl/ql_bank_bl_wl_sequencer.sv
// Replays each accepted word as a SETUP -> PULSE -> HOLD bl/wl write cycle on one QL memory bank.
// Define QL_BANK_SEQ_PARITY_EN to drop words whose cfg_parity mismatches the XOR of address and data.
module ql_bank_bl_wl_sequencer #(
  parameter int BL_WIDTH     = 6,
  parameter int WL_WIDTH     = 6,
  parameter int WL_ADDR_W    = 3,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input logic                      prog_clk,
  input logic                      prog_reset,
  ql_bank_bl_wl_sequencer_if.slave cfg
);

  localparam int MAX_C0 = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
  localparam int MAX_C  = (MAX_C0 > HOLD_CYCLES) ? MAX_C0 : HOLD_CYCLES;
  localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;
  localparam logic [31:0] WL_LIMIT = WL_WIDTH;

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [WL_ADDR_W-1:0] addr_q, addr_d;
  logic [0:BL_WIDTH-1]  data_q, data_d;
  logic [0:BL_WIDTH-1]  bl_q, bl_d;
  logic [0:WL_WIDTH-1]  wl_q, wl_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rdy_en_q;
  logic                 accept;
  logic                 addr_ok;
  logic                 parity_ok;
  logic                 err_set;

  // rdy_en_q keeps cfg_ready low until the first edge after reset release.
  assign cfg.cfg_ready = (state_q == IDLE) && rdy_en_q;
  assign accept        = cfg.cfg_valid && cfg.cfg_ready;
  assign addr_ok       = ({{(32-WL_ADDR_W){1'b0}}, cfg.cfg_wl_addr} < WL_LIMIT);

`ifdef QL_BANK_SEQ_PARITY_EN
  assign parity_ok = (cfg.cfg_parity == (^{cfg.cfg_wl_addr, cfg.cfg_bl_data}));
`else
  assign parity_ok = 1'b1;
`endif

  assign cfg.bl   = bl_q;
  assign cfg.wl   = wl_q;
  assign cfg.busy = (state_q != IDLE);
  assign cfg.done = done_q;
  assign cfg.err  = err_q;

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      bl_q     <= '0;
      wl_q     <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      bl_q     <= bl_d;
      wl_q     <= wl_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (addr_ok && parity_ok) begin
            state_d = SETUP;
            cnt_d   = CNT_W'(SETUP_CYCLES - 1);
            addr_d  = cfg.cfg_wl_addr;
            data_d  = cfg.cfg_bl_data;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = CNT_W'(PULSE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they land in registers and never glitch.
  always_comb begin
    bl_d   = (state_d != IDLE) ? data_d : '0;
    wl_d   = '0;
    for (int i = 0; i < WL_WIDTH; i++) begin
      wl_d[i] = (state_d == PULSE) && (addr_d == WL_ADDR_W'(i));
    end
    done_d = (state_q == HOLD) && (state_d == IDLE);
    err_d  = err_set ? 1'b1 : (cfg.clr_err ? 1'b0 : err_q);
  end

endmodule

// File: tb/tb_ql_bank_bl_wl_sequencer.sv
// Directed self-checking bench for ql_bank_bl_wl_sequencer (vector table plus multi-cycle sequences).
module tb_ql_bank_bl_wl_sequencer;

  logic prog_clk = 1'b0;
  logic prog_reset;

  always #5 prog_clk = ~prog_clk;

  ql_bank_bl_wl_sequencer_if #(.BL_WIDTH(6), .WL_WIDTH(6), .WL_ADDR_W(3)) bus ();

  ql_bank_bl_wl_sequencer #(
    .BL_WIDTH(6), .WL_WIDTH(6), .WL_ADDR_W(3),
    .SETUP_CYCLES(1), .PULSE_CYCLES(2), .HOLD_CYCLES(1)
  ) dut (
    .prog_clk  (prog_clk),
    .prog_reset(prog_reset),
    .cfg       (bus)
  );

`ifdef QL_BANK_SEQ_PARITY_EN
  logic par_flip = 1'b0;
  assign bus.cfg_parity = (^{bus.cfg_wl_addr, bus.cfg_bl_data}) ^ par_flip;
`endif

  typedef struct {
    logic       v;
    logic [2:0] a;
    logic [5:0] d;
    logic       clr;
    logic [5:0] bl;
    logic [5:0] wl;
    logic       rdy;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  vec_t       vt[10];
  int         n_chk = 0;
  int         n_fail = 0;
  int         acc_cyc[3];
  int         pulses[6];
  int         k, multi, dones, wl_seen;
  logic [2:0] words[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge prog_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // {valid, addr, data, clr_err} -> {bl, wl, ready, busy, done, err} after the next edge
    vt[0] = '{1'b1, 3'd2, 6'b101101, 1'b0, 6'b101101, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[1] = '{1'b1, 3'd5, 6'b010010, 1'b0, 6'b101101, 6'b001000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 3'd5, 6'b010010, 1'b0, 6'b101101, 6'b001000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 3'd5, 6'b010010, 1'b0, 6'b101101, 6'b000000, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[4] = '{1'b0, 3'd5, 6'b010010, 1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 3'd7, 6'b111111, 1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b0, 3'd7, 6'b111111, 1'b1, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[7] = '{1'b0, 3'd0, 6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b1, 3'd6, 6'b000000, 1'b1, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b1};
    vt[9] = '{1'b0, 3'd0, 6'b000000, 1'b1, 6'b000000, 6'b000000, 1'b1, 1'b0, 1'b0, 1'b0};
    words[0] = 3'd0;
    words[1] = 3'd5;
    words[2] = 3'd3;

    prog_reset      = 1'b1;
    bus.cfg_valid   = 1'b0;
    bus.cfg_wl_addr = '0;
    bus.cfg_bl_data = '0;
    bus.clr_err     = 1'b0;
    #12;
    check("rst bl", bus.bl, 0);
    check("rst wl", bus.wl, 0);
    check("rst busy", bus.busy, 0);
    check("rst done", bus.done, 0);
    check("rst err", bus.err, 0);
    check("rst ready", bus.cfg_ready, 0);
    step();
    prog_reset = 1'b0;
    check("ready before first edge", bus.cfg_ready, 0);
    step();
    check("ready after first edge", bus.cfg_ready, 1);

    for (int i = 0; i < 10; i++) begin
      bus.cfg_valid   = vt[i].v;
      bus.cfg_wl_addr = vt[i].a;
      bus.cfg_bl_data = vt[i].d;
      bus.clr_err     = vt[i].clr;
      step();
      check($sformatf("vec%0d bl", i), bus.bl, vt[i].bl);
      check($sformatf("vec%0d wl", i), bus.wl, vt[i].wl);
      check($sformatf("vec%0d ready", i), bus.cfg_ready, vt[i].rdy);
      check($sformatf("vec%0d busy", i), bus.busy, vt[i].busy);
      check($sformatf("vec%0d done", i), bus.done, vt[i].done);
      check($sformatf("vec%0d err", i), bus.err, vt[i].err);
    end
    bus.cfg_valid = 1'b0;
    bus.clr_err   = 1'b0;

    // Back-to-back words with cfg_valid held high
    k = 0; multi = 0; dones = 0;
    for (int b = 0; b < 6; b++) pulses[b] = 0;
    for (int j = 0; j < 3; j++) acc_cyc[j] = -100;
    bus.cfg_valid   = 1'b1;
    bus.cfg_wl_addr = words[0];
    bus.cfg_bl_data = 6'b110011;
    for (int c = 0; c < 30; c++) begin
      if (bus.cfg_ready && bus.cfg_valid && k < 3) begin
        acc_cyc[k] = c;
        k++;
      end
      step();
      if ($countones(bus.wl) > 1) multi++;
      for (int b = 0; b < 6; b++) if (bus.wl[b]) pulses[b]++;
      if (bus.done) dones++;
      if (k < 3) bus.cfg_wl_addr = words[k];
      else bus.cfg_valid = 1'b0;
    end
    check("b2b accepted words", k, 3);
    check("b2b spacing 0-1", acc_cyc[1] - acc_cyc[0], 5);
    check("b2b spacing 1-2", acc_cyc[2] - acc_cyc[1], 5);
    check("b2b multi-hot wl cycles", multi, 0);
    check("b2b done pulses", dones, 3);
    for (int b = 0; b < 6; b++)
      check($sformatf("b2b wl[%0d] pulse cycles", b), pulses[b],
            (b == 0 || b == 5 || b == 3) ? 2 : 0);

    // Reset during PULSE, with err already set
    bus.cfg_valid   = 1'b1;
    bus.cfg_wl_addr = 3'd7;
    step();
    check("pre-reset err", bus.err, 1);
    bus.cfg_wl_addr = 3'd4;
    bus.cfg_bl_data = 6'b111111;
    step();
    bus.cfg_valid = 1'b0;
    step();
    check("pre-reset pulse wl", bus.wl, 6'b000010);
    #2;
    prog_reset = 1'b1;
    #1;
    check("async rst wl", bus.wl, 0);
    check("async rst bl", bus.bl, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst err", bus.err, 0);
    step();
    prog_reset = 1'b0;
    step();
    check("post-rst ready", bus.cfg_ready, 1);
    check("post-rst err", bus.err, 0);
    wl_seen = 0; dones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.wl != 0) wl_seen++;
      if (bus.done) dones++;
    end
    check("abandoned write wl", wl_seen, 0);
    check("abandoned write done", dones, 0);

`ifdef QL_BANK_SEQ_PARITY_EN
    par_flip        = 1'b1;
    bus.cfg_valid   = 1'b1;
    bus.cfg_wl_addr = 3'd1;
    bus.cfg_bl_data = 6'b000011;
    step();
    bus.cfg_valid = 1'b0;
    par_flip      = 1'b0;
    check("parity bad err", bus.err, 1);
    check("parity bad ready", bus.cfg_ready, 1);
    wl_seen = 0; dones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (bus.wl != 0) wl_seen++;
      if (bus.done) dones++;
    end
    check("parity bad wl", wl_seen, 0);
    check("parity bad done", dones, 0);
    bus.clr_err = 1'b1;
    step();
    bus.clr_err = 1'b0;
    check("parity clr err", bus.err, 0);
    bus.cfg_valid = 1'b1;
    step();
    bus.cfg_valid = 1'b0;
    wl_seen = 0; dones = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (bus.wl == 6'b010000) wl_seen++;
      if (bus.done) dones++;
    end
    check("parity good wl[1] cycles", wl_seen, 2);
    check("parity good done", dones, 1);
    check("parity good err", bus.err, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
